// File: rtl/pc_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_sequencer_if
//  Description : Fetch-side bundle between the program ROM, the execute
//                stage and the PC / fetch sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_sequencer_if;
    logic        stall;
    logic [13:0] rom_data_in;
    logic [10:0] rom_addr_out;
    logic        jump_valid;
    logic        call_valid;
    logic [10:0] jump_target;
    logic        ret_valid;
    logic        skip_valid;
    logic [13:0] ir_out;
    logic        ir_valid;
    logic [10:0] ir_pc;
    logic [3:0]  stack_depth;
    logic        stack_ovf;
    logic        stack_unf;

    // Environment side: ROM data, stall and execute-stage redirects
    modport master (
        output stall, rom_data_in, jump_valid, call_valid, jump_target,
               ret_valid, skip_valid,
        input  rom_addr_out, ir_out, ir_valid, ir_pc, stack_depth,
               stack_ovf, stack_unf
    );

    // Fetch sequencer side
    modport slave (
        input  stall, rom_data_in, jump_valid, call_valid, jump_target,
               ret_valid, skip_valid,
        output rom_addr_out, ir_out, ir_valid, ir_pc, stack_depth,
               stack_ovf, stack_unf
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_sequencer
//  Description : Program counter, instruction register and circular return
//                stack for the 14-bit-instruction core. Handles GOTO, CALL,
//                RETURN and skip redirects from execute.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer #(
    parameter logic [10:0] RESET_VECTOR = 11'h000,
    parameter int          STACK_DEPTH  = 8,
    parameter logic [13:0] NOP_WORD     = 14'h0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pc_fetch_sequencer_if.slave  fetch
);

    localparam int         c_sp_w       = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [3:0] c_depth_full = 4'(STACK_DEPTH);

    typedef enum logic [1:0] {
        S_PRIME = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    logic [10:0]         r_pc;
    logic [13:0]         r_ir;
    logic                r_ir_valid;
    logic [10:0]         r_ir_pc;
    logic [c_sp_w-1:0]   r_sp;
    logic [3:0]          r_depth;
    logic                r_ovf;
    logic                r_unf;
    logic [10:0]         r_stack [STACK_DEPTH];

    logic                w_run;
    logic                w_ret;
    logic                w_call;
    logic                w_jump;
    logic                w_skip;
    logic [10:0]         w_pc_inc;
    logic [c_sp_w-1:0]   w_sp_inc;
    logic [c_sp_w-1:0]   w_sp_dec;

    // Requests only count in RUN and when not stalled; priority ret > call > jump > skip
    assign w_run    = !fetch.stall && (r_state == S_RUN);
    assign w_ret    = w_run && fetch.ret_valid;
    assign w_call   = w_run && !fetch.ret_valid && fetch.call_valid;
    assign w_jump   = w_run && !fetch.ret_valid && !fetch.call_valid && fetch.jump_valid;
    assign w_skip   = w_run && !fetch.ret_valid && !fetch.call_valid && !fetch.jump_valid
                      && fetch.skip_valid;

    // 11-bit PC and stack pointer wrap naturally at their widths
    assign w_pc_inc = r_pc + 11'd1;
    assign w_sp_inc = r_sp + c_sp_w'(1);
    assign w_sp_dec = r_sp - c_sp_w'(1);

    // Sequencer FSM, PC, IR and stack bookkeeping; everything freezes under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_PRIME;
            r_pc       <= RESET_VECTOR;
            r_ir       <= NOP_WORD;
            r_ir_valid <= 1'b0;
            r_ir_pc    <= 11'h000;
            r_sp       <= '0;
            r_depth    <= 4'd0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else if (!fetch.stall) begin
            case (r_state)
                S_RUN: begin
                    if (w_ret) begin
                        // Pop: stale entry is still used on underflow
                        r_pc       <= r_stack[w_sp_dec];
                        r_sp       <= w_sp_dec;
                        if (r_depth != 4'd0) begin
                            r_depth <= r_depth - 4'd1;
                        end else begin
                            r_unf   <= 1'b1;
                        end
                        r_ir       <= NOP_WORD;
                        r_ir_valid <= 1'b0;
                        r_state    <= S_FLUSH;
                    end else if (w_call) begin
                        // Push of the return address happens in the stack write block
                        r_pc       <= fetch.jump_target;
                        r_sp       <= w_sp_inc;
                        if (r_depth != c_depth_full) begin
                            r_depth <= r_depth + 4'd1;
                        end else begin
                            r_ovf   <= 1'b1;
                        end
                        r_ir       <= NOP_WORD;
                        r_ir_valid <= 1'b0;
                        r_state    <= S_FLUSH;
                    end else if (w_jump) begin
                        r_pc       <= fetch.jump_target;
                        r_ir       <= NOP_WORD;
                        r_ir_valid <= 1'b0;
                        r_state    <= S_FLUSH;
                    end else if (w_skip) begin
                        // The word at PC is dropped, leaving a single bubble
                        r_ir       <= NOP_WORD;
                        r_ir_valid <= 1'b0;
                        r_ir_pc    <= r_pc;
                        r_pc       <= w_pc_inc;
                    end else begin
                        r_ir       <= fetch.rom_data_in;
                        r_ir_pc    <= r_pc;
                        r_ir_valid <= 1'b1;
                        r_pc       <= w_pc_inc;
                    end
                end
                S_PRIME, S_FLUSH: begin
                    // Plain fetch at the current PC; redirects are ignored here
                    r_ir       <= fetch.rom_data_in;
                    r_ir_pc    <= r_pc;
                    r_ir_valid <= 1'b1;
                    r_pc       <= w_pc_inc;
                    r_state    <= S_RUN;
                end
                default: begin
                    r_state    <= S_PRIME;
                end
            endcase
        end
    end

    // Return stack storage; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (w_call) begin
            r_stack[r_sp] <= r_pc;
        end
    end

    assign fetch.rom_addr_out = r_pc;
    assign fetch.ir_out       = r_ir;
    assign fetch.ir_valid     = r_ir_valid;
    assign fetch.ir_pc        = r_ir_pc;
    assign fetch.stack_depth  = r_depth;
    assign fetch.stack_ovf    = r_ovf;
    assign fetch.stack_unf    = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_sequencer
//  Description : Directed bench for pc_fetch_sequencer with a behavioural
//                fetch/stack model and per-cycle output comparison.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_sequencer;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [13:0] rom [2048];

    pc_fetch_sequencer_if bus ();

    pc_fetch_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fetch (bus)
    );

    assign bus.rom_data_in = rom[bus.rom_addr_out];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: a "refill" flag marks the cycle after reset or a redirect
    int          m_pc;
    bit          m_refill;
    logic [13:0] m_ir;
    bit          m_valid;
    int          m_ir_pc;
    int          m_stk [8];
    int          m_sp;
    int          m_depth;
    bit          m_ovf;
    bit          m_unf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_fetch();
        m_ir    = rom[m_pc];
        m_ir_pc = m_pc;
        m_valid = 1'b1;
        m_pc    = (m_pc + 1) % 2048;
    endtask

    task automatic m_redirect(input int target);
        m_pc     = target;
        m_ir     = 14'h0000;
        m_valid  = 1'b0;
        m_refill = 1'b1;
    endtask

    // Behavioural model stepped on every clock edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 0; m_refill = 1'b1; m_ir = 14'h0000; m_valid = 1'b0;
            m_ir_pc = 0; m_sp = 0; m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
        end else if (!bus.stall) begin
            if (m_refill) begin
                m_fetch();
                m_refill = 1'b0;
            end else if (bus.ret_valid) begin
                m_sp = (m_sp + 7) % 8;
                if (m_depth == 0) m_unf = 1'b1; else m_depth--;
                m_redirect(m_stk[m_sp]);
            end else if (bus.call_valid) begin
                m_stk[m_sp] = m_pc;
                m_sp = (m_sp + 1) % 8;
                if (m_depth == 8) m_ovf = 1'b1; else m_depth++;
                m_redirect(int'(bus.jump_target));
            end else if (bus.jump_valid) begin
                m_redirect(int'(bus.jump_target));
            end else if (bus.skip_valid) begin
                m_ir    = 14'h0000;
                m_valid = 1'b0;
                m_ir_pc = m_pc;
                m_pc    = (m_pc + 1) % 2048;
            end else begin
                m_fetch();
            end
        end
    end

    // Compare DUT against the model shortly after every rising edge
    always @(posedge clk) begin
        #1;
        check("rom_addr", 32'(bus.rom_addr_out), 32'(m_pc));
        check("ir_out", 32'(bus.ir_out), 32'(m_ir));
        check("ir_valid", 32'(bus.ir_valid), 32'(m_valid));
        if (m_valid) check("ir_pc", 32'(bus.ir_pc), 32'(m_ir_pc));
        check("stack_depth", 32'(bus.stack_depth), 32'(m_depth));
        check("stack_ovf", 32'(bus.stack_ovf), 32'(m_ovf));
        check("stack_unf", 32'(bus.stack_unf), 32'(m_unf));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_req();
        bus.jump_valid = 1'b0;
        bus.call_valid = 1'b0;
        bus.ret_valid  = 1'b0;
        bus.skip_valid = 1'b0;
    endtask

    // Issue one redirect-type request for a single cycle
    task automatic pulse(input bit j, input bit c, input bit r, input bit s, input logic [10:0] tgt);
        bus.jump_valid  = j;
        bus.call_valid  = c;
        bus.ret_valid   = r;
        bus.skip_valid  = s;
        bus.jump_target = tgt;
        tick();
        clear_req();
    endtask

    task automatic check_reset_values();
        check("rst_addr", 32'(bus.rom_addr_out), 32'h000);
        check("rst_ir", 32'(bus.ir_out), 32'h0000);
        check("rst_valid", 32'(bus.ir_valid), 32'd0);
        check("rst_ir_pc", 32'(bus.ir_pc), 32'h000);
        check("rst_depth", 32'(bus.stack_depth), 32'd0);
        check("rst_ovf", 32'(bus.stack_ovf), 32'd0);
        check("rst_unf", 32'(bus.stack_unf), 32'd0);
    endtask

    logic [10:0] saved_pc;
    logic [13:0] saved_ir;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 2048; i++) rom[i] = 14'((i * 97 + 13) % 16384);
        rom[0]  = 14'h3003;
        rom[1]  = 14'h01A5;
        rom[2]  = 14'h000B;
        rom[5]  = 14'h0825;
        rom[6]  = 14'h0825;
        rom[10] = 14'h3400;

        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.jump_target = 11'h000;
        clear_req();
        #7;
        check_reset_values();

        // Reset release and sequential fetch
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("c1_ir", 32'(bus.ir_out), 32'h3003);
        check("c1_pc", 32'(bus.ir_pc), 32'h000);
        check("c1_valid", 32'(bus.ir_valid), 32'd1);
        check("c1_addr", 32'(bus.rom_addr_out), 32'h001);
        tick();
        check("c2_ir", 32'(bus.ir_out), 32'h01A5);
        check("c2_addr", 32'(bus.rom_addr_out), 32'h002);
        tick();
        check("c3_pc", 32'(bus.ir_pc), 32'h002);
        check("c3_addr", 32'(bus.rom_addr_out), 32'h003);

        // GOTO 0x00A
        pulse(1, 0, 0, 0, 11'h00A);
        check("goto_bubble_valid", 32'(bus.ir_valid), 32'd0);
        check("goto_bubble_ir", 32'(bus.ir_out), 32'h0000);
        tick();
        check("goto_ir", 32'(bus.ir_out), 32'h3400);
        check("goto_pc", 32'(bus.ir_pc), 32'h00A);

        // CALL from 5 to 0x008, then RETURN to 6
        pulse(1, 0, 0, 0, 11'h004);
        tick();
        tick();
        check("pre_call_pc", 32'(bus.ir_pc), 32'h005);
        pulse(0, 1, 0, 0, 11'h008);
        check("call_depth", 32'(bus.stack_depth), 32'd1);
        tick();
        check("call_pc", 32'(bus.ir_pc), 32'h008);
        tick();
        pulse(0, 0, 1, 0, 11'h000);
        check("ret_depth", 32'(bus.stack_depth), 32'd0);
        tick();
        check("ret_pc", 32'(bus.ir_pc), 32'h006);
        check("ret_ir", 32'(bus.ir_out), 32'h0825);

        // Skip at ir_pc = 3
        pulse(1, 0, 0, 0, 11'h003);
        tick();
        check("pre_skip_pc", 32'(bus.ir_pc), 32'h003);
        pulse(0, 0, 0, 1, 11'h000);
        check("skip_bubble", 32'(bus.ir_valid), 32'd0);
        tick();
        check("skip_pc", 32'(bus.ir_pc), 32'h005);
        check("skip_ir", 32'(bus.ir_out), 32'h0825);

        // Stall for three cycles with a jump request held that must be ignored
        tick();
        saved_pc = bus.ir_pc;
        saved_ir = bus.ir_out;
        bus.stall = 1'b1;
        bus.jump_valid = 1'b1;
        bus.jump_target = 11'h055;
        repeat (3) begin
            tick();
            check("stall_pc", 32'(bus.ir_pc), 32'(saved_pc));
            check("stall_ir", 32'(bus.ir_out), 32'(saved_ir));
            check("stall_addr", 32'(bus.rom_addr_out), 32'(saved_pc + 11'd1));
        end
        bus.stall = 1'b0;
        clear_req();
        tick();
        check("post_stall_pc", 32'(bus.ir_pc), 32'(saved_pc + 11'd1));

        // Nine CALLs; the fifth also raises jump and skip, which must lose
        for (int i = 0; i < 9; i++) begin
            pulse((i == 4), 1, 0, (i == 4), 11'(32'h100 + 16 * i));
            tick();
            if (i == 7) check("depth8_ovf_clear", 32'(bus.stack_ovf), 32'd0);
        end
        check("ovf_depth", 32'(bus.stack_depth), 32'd8);
        check("ovf_flag", 32'(bus.stack_ovf), 32'd1);

        // Nine RETURNs; the third also raises call, which must lose
        for (int j = 1; j <= 9; j++) begin
            pulse(0, (j == 3), 1, 0, 11'h3F0);
            tick();
            if (j == 8) begin
                check("ret8_pc", 32'(bus.ir_pc), 32'h101);
                check("ret8_depth", 32'(bus.stack_depth), 32'd0);
                check("ret8_unf_clear", 32'(bus.stack_unf), 32'd0);
            end
        end
        check("unf_flag", 32'(bus.stack_unf), 32'd1);
        check("ret9_stale_pc", 32'(bus.ir_pc), 32'h171);
        check("sticky_ovf", 32'(bus.stack_ovf), 32'd1);

        // PC wrap at 0x7FF
        pulse(1, 0, 0, 0, 11'h7FE);
        tick();
        check("wrap_pre_addr", 32'(bus.rom_addr_out), 32'h7FF);
        tick();
        check("wrap_pc", 32'(bus.ir_pc), 32'h7FF);
        check("wrap_addr", 32'(bus.rom_addr_out), 32'h000);

        // Asynchronous reset in the middle of a FLUSH cycle
        pulse(1, 0, 0, 0, 11'h020);
        check("flush_addr", 32'(bus.rom_addr_out), 32'h020);
        #3 rst_n = 1'b0;
        #1;
        check_reset_values();
        tick();
        rst_n = 1'b1;
        tick();
        check("restart_ir", 32'(bus.ir_out), 32'h3003);
        check("restart_pc", 32'(bus.ir_pc), 32'h000);
        check("restart_valid", 32'(bus.ir_valid), 32'd1);
        tick();
        check("restart_pc2", 32'(bus.ir_pc), 32'h001);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
